// File: rtl/mfp_ahb_sdram_wbuf.sv
// rtl/mfp_ahb_sdram_wbuf.sv - posted-write FIFO between the AHB-Lite system bus and the SDRAM controller slave port.
// Writes retire upstream with zero wait while a slot is free; reads stall until the FIFO has drained.
module mfp_ahb_sdram_wbuf #(
  parameter int FIFO_LOG2 = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        M_HSEL,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY,
  output logic        wbuf_empty
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = {1'b1, {FIFO_LOG2{1'b0}}};
  localparam logic [FIFO_LOG2:0] ONE_CNT  = {{FIFO_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {M_IDLE, M_WADDR, M_WDATA, M_RADDR, M_RDATA} mstate_t;

  mstate_t                state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic                   dphase_q, dphase_d;
  logic                   rd_done_q, rd_done_d;
  logic [31:0]            hrdata_q, hrdata_d;
  logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [FIFO_LOG2:0]     count_q, count_d;
  logic                   empty_q, empty_d;
  logic                   m_hsel_q, m_hsel_d, m_hwrite_q, m_hwrite_d;
  logic [31:0]            m_haddr_q, m_haddr_d, m_hwdata_q, m_hwdata_d;
  logic [1:0]             m_htrans_q, m_htrans_d;
  logic [2:0]             m_hsize_q, m_hsize_d;
  logic [31:0]            fifo_addr_q [DEPTH];
  logic [31:0]            fifo_data_q [DEPTH];
  logic [2:0]             fifo_size_q [DEPTH];
  logic                   hready, accept, push, pop;
  logic                   unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Full check uses registered count so a same-cycle pop cannot admit a write.
  always_comb begin
    hready = 1'b1;
    if (dphase_q) hready = write_q ? (count_q != FULL_CNT) : rd_done_q;
  end

  assign accept = HSEL && HTRANS[1] && hready;
  assign push   = dphase_q && write_q && hready;
  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    dphase_d = dphase_q;
    if (dphase_q && hready) dphase_d = 1'b0;
    if (accept) begin
      addr_d   = HADDR;
      write_d  = HWRITE;
      size_d   = HSIZE;
      dphase_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rd_done_d  = 1'b0;
    hrdata_d   = hrdata_q;
    m_hsel_d   = m_hsel_q;
    m_haddr_d  = m_haddr_q;
    m_htrans_d = m_htrans_q;
    m_hwrite_d = m_hwrite_q;
    m_hsize_d  = m_hsize_q;
    m_hwdata_d = m_hwdata_q;
    case (state_q)
      M_IDLE: begin
        if (count_q != '0) begin
          m_hsel_d   = 1'b1;
          m_htrans_d = 2'b10;
          m_hwrite_d = 1'b1;
          m_haddr_d  = fifo_addr_q[rd_ptr_q];
          m_hsize_d  = fifo_size_q[rd_ptr_q];
          state_d    = M_WADDR;
        end else if (dphase_q && !write_q && !rd_done_q) begin
          m_hsel_d   = 1'b1;
          m_htrans_d = 2'b10;
          m_hwrite_d = 1'b0;
          m_haddr_d  = addr_q;
          m_hsize_d  = size_q;
          state_d    = M_RADDR;
        end
      end
      M_WADDR: begin
        if (M_HREADY) begin
          m_hsel_d   = 1'b0;
          m_htrans_d = 2'b00;
          m_hwdata_d = fifo_data_q[rd_ptr_q];
          state_d    = M_WDATA;
        end
      end
      M_WDATA: begin
        if (M_HREADY) begin
          pop     = 1'b1;
          state_d = M_IDLE;
          // Chain straight into the next queued write without an idle cycle.
          if (count_q > ONE_CNT) begin
            m_hsel_d   = 1'b1;
            m_htrans_d = 2'b10;
            m_hwrite_d = 1'b1;
            m_haddr_d  = fifo_addr_q[rd_nxt];
            m_hsize_d  = fifo_size_q[rd_nxt];
            state_d    = M_WADDR;
          end
        end
      end
      M_RADDR: begin
        if (M_HREADY) begin
          m_hsel_d   = 1'b0;
          m_htrans_d = 2'b00;
          state_d    = M_RDATA;
        end
      end
      M_RDATA: begin
        if (M_HREADY) begin
          hrdata_d  = M_HRDATA;
          rd_done_d = 1'b1;
          state_d   = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= addr_q;
      fifo_data_q[wr_ptr_q] <= HWDATA;
      fifo_size_q[wr_ptr_q] <= size_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= M_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      dphase_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      hrdata_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      m_hsel_q   <= 1'b0;
      m_haddr_q  <= '0;
      m_htrans_q <= 2'b00;
      m_hwrite_q <= 1'b0;
      m_hsize_q  <= '0;
      m_hwdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      dphase_q   <= dphase_d;
      rd_done_q  <= rd_done_d;
      hrdata_q   <= hrdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      m_hsel_q   <= m_hsel_d;
      m_haddr_q  <= m_haddr_d;
      m_htrans_q <= m_htrans_d;
      m_hwrite_q <= m_hwrite_d;
      m_hsize_q  <= m_hsize_d;
      m_hwdata_q <= m_hwdata_d;
    end
  end

  assign HREADY     = hready;
  assign HRDATA     = hrdata_q;
  assign HRESP      = 1'b0;
  assign M_HSEL     = m_hsel_q;
  assign M_HADDR    = m_haddr_q;
  assign M_HTRANS   = m_htrans_q;
  assign M_HWRITE   = m_hwrite_q;
  assign M_HSIZE    = m_hsize_q;
  assign M_HWDATA   = m_hwdata_q;
  assign wbuf_empty = empty_q;
endmodule

// File: tb/tb_mfp_ahb_sdram_wbuf.sv
// tb/tb_mfp_ahb_sdram_wbuf.sv - directed bench for the SDRAM posted-write buffer.
module tb_mfp_ahb_sdram_wbuf;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA, M_HADDR, M_HWDATA, M_HRDATA;
  logic        HSEL, HWRITE, HREADY, HRESP, M_HSEL, M_HWRITE, M_HREADY, wbuf_empty;
  logic [1:0]  HTRANS, M_HTRANS;
  logic [2:0]  HSIZE, M_HSIZE;

  int n_checks = 0;
  int n_pass   = 0;

  mfp_ahb_sdram_wbuf #(.FIFO_LOG2(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA),
    .M_HREADY(M_HREADY), .wbuf_empty(wbuf_empty)
  );

  always #5 HCLK = ~HCLK;

  // Downstream slave model: RAM plus a log of completed writes and address phases.
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = 32'h0;
  logic [31:0] mem [0:255];
  logic [31:0] wr_log_a [$];
  logic [31:0] wr_log_d [$];
  int          wr_ap_cnt = 0;
  int          rd_ap_cnt = 0;

  assign M_HRDATA = mem[dp_addr[9:2]];

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
    end else if (M_HREADY) begin
      if (dp_valid && dp_write) begin
        mem[dp_addr[9:2]] <= M_HWDATA;
        wr_log_a.push_back(dp_addr);
        wr_log_d.push_back(M_HWDATA);
      end
      dp_valid <= M_HSEL && M_HTRANS[1];
      dp_addr  <= M_HADDR;
      dp_write <= M_HWRITE;
      if (M_HSEL && M_HTRANS[1]) begin
        if (M_HWRITE) wr_ap_cnt++;
        else          rd_ap_cnt++;
      end
    end
  end

  // Pipelined upstream master over a small op table.
  bit          op_w [8];
  logic [31:0] op_a [8];
  logic [31:0] op_d [8];
  int          op_wait [8];
  logic [31:0] op_rd [8];
  bit          op_timeout;

  task automatic run_ops(input int n);
    int ap, dp, guard;
    bit rdy;
    ap = 0; dp = -1; guard = 0; op_timeout = 1'b0;
    for (int i = 0; i < 8; i++) op_wait[i] = 0;
    while ((ap < n || dp >= 0) && guard < 400) begin
      @(negedge HCLK);
      if (ap < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = op_w[ap]; HADDR = op_a[ap];
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
      end
      HWDATA = (dp >= 0 && op_w[dp]) ? op_d[dp] : 32'h0;
      #1;
      rdy = HREADY;
      if (rdy && dp >= 0 && !op_w[dp]) op_rd[dp] = HRDATA;
      @(posedge HCLK);
      if (rdy) begin
        dp = (ap < n) ? ap : -1;
        if (ap < n) ap++;
      end else if (dp >= 0) begin
        op_wait[dp]++;
      end
      guard++;
    end
    if (guard >= 400) op_timeout = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
  endtask

  task automatic wait_drain(input int n_wr, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge HCLK);
      #1;
      if (wbuf_empty && wr_log_a.size() >= n_wr && M_HTRANS == 2'b00) ok = 1'b1;
    end
  endtask

  task automatic clear_logs();
    wr_log_a.delete();
    wr_log_d.delete();
    wr_ap_cnt = 0;
    rd_ap_cnt = 0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    HSIZE = 3'b010; HWDATA = 32'h0; M_HREADY = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    n_checks++; if (HREADY !== 1'b1) $display("FAIL reset_hready got %b want 1", HREADY); else n_pass++;
    n_checks++; if (M_HTRANS !== 2'b00) $display("FAIL reset_m_htrans got %b want 00", M_HTRANS); else n_pass++;
    n_checks++; if (wbuf_empty !== 1'b1) $display("FAIL reset_wbuf_empty got %b want 1", wbuf_empty); else n_pass++;
    n_checks++; if (HRDATA !== 32'h0) $display("FAIL reset_hrdata got %h want 0", HRDATA); else n_pass++;
    n_checks++; if (M_HSEL !== 1'b0) $display("FAIL reset_m_hsel got %b want 0", M_HSEL); else n_pass++;
    n_checks++; if (M_HADDR !== 32'h0) $display("FAIL reset_m_haddr got %h want 0", M_HADDR); else n_pass++;
    n_checks++; if (M_HWDATA !== 32'h0) $display("FAIL reset_m_hwdata got %h want 0", M_HWDATA); else n_pass++;
    n_checks++; if (HRESP !== 1'b0) $display("FAIL reset_hresp got %b want 0", HRESP); else n_pass++;
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    clear_logs();
    M_HREADY = 1'b1;
    op_w[0] = 1'b1; op_a[0] = 32'h0000_0010; op_d[0] = 32'hDEAD_BEEF;
    run_ops(1);
    n_checks++; if (op_timeout !== 1'b0) $display("FAIL single_timeout got %b want 0", op_timeout); else n_pass++;
    n_checks++; if (op_wait[0] !== 0) $display("FAIL single_wait got %0d want 0", op_wait[0]); else n_pass++;
    wait_drain(1, 20, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_drain got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_log_a.size() !== 1) $display("FAIL single_count got %0d want 1", wr_log_a.size()); else n_pass++;
    if (wr_log_a.size() >= 1) begin
      n_checks++; if (wr_log_a[0] !== 32'h10) $display("FAIL single_addr got %h want 00000010", wr_log_a[0]); else n_pass++;
      n_checks++; if (wr_log_d[0] !== 32'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", wr_log_d[0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    M_HREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op_w[i] = 1'b1; op_a[i] = 32'h100 + 32'(i * 4); op_d[i] = 32'hA000_0000 + 32'(i);
    end
    fork
      begin
        repeat (20) @(negedge HCLK);
        M_HREADY = 1'b1;
      end
    join_none
    run_ops(6);
    n_checks++; if (op_timeout !== 1'b0) $display("FAIL b2b_timeout got %b want 0", op_timeout); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (op_wait[i] !== 0) $display("FAIL b2b_wait%0d got %0d want 0", i, op_wait[i]); else n_pass++;
    end
    n_checks++; if (op_wait[4] < 10) $display("FAIL b2b_wait4 got %0d want >=10", op_wait[4]); else n_pass++;
    wait_drain(6, 100, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b_drain got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_log_a.size() !== 6) $display("FAIL b2b_count got %0d want 6", wr_log_a.size()); else n_pass++;
    for (int i = 0; i < 6 && i < wr_log_a.size(); i++) begin
      n_checks++;
      if (wr_log_a[i] !== op_a[i] || wr_log_d[i] !== op_d[i])
        $display("FAIL b2b_entry%0d got %h/%h want %h/%h", i, wr_log_a[i], wr_log_d[i], op_a[i], op_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    clear_logs();
    M_HREADY = 1'b1;
    op_w[0] = 1'b1; op_a[0] = 32'h20; op_d[0] = 32'h1234_5678;
    op_w[1] = 1'b0; op_a[1] = 32'h20; op_d[1] = 32'h0;
    run_ops(2);
    n_checks++; if (op_timeout !== 1'b0) $display("FAIL wr_rd_timeout got %b want 0", op_timeout); else n_pass++;
    n_checks++; if (op_wait[0] !== 0) $display("FAIL wr_rd_wwait got %0d want 0", op_wait[0]); else n_pass++;
    n_checks++; if (op_rd[1] !== 32'h1234_5678) $display("FAIL wr_rd_data got %h want 12345678", op_rd[1]); else n_pass++;
    n_checks++; if (op_wait[1] !== 6) $display("FAIL wr_rd_latency got %0d want 6", op_wait[1]); else n_pass++;
    repeat (10) @(negedge HCLK);
    n_checks++; if (rd_ap_cnt !== 1) $display("FAIL wr_rd_reads got %0d want 1", rd_ap_cnt); else n_pass++;
    n_checks++; if (wr_log_a.size() !== 1) $display("FAIL wr_rd_writes got %0d want 1", wr_log_a.size()); else n_pass++;
  endtask

  task automatic test_refresh_stall();
    bit ok, seen;
    int bad;
    clear_logs();
    M_HREADY = 1'b0;
    op_w[0] = 1'b1; op_a[0] = 32'h40; op_d[0] = 32'hCAFE_F00D;
    run_ops(1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge HCLK);
      #1;
      if (M_HTRANS == 2'b10) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL stall_addr_seen got %b want 1", seen); else n_pass++;
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge HCLK);
      #1;
      if (M_HADDR !== 32'h40 || M_HTRANS !== 2'b10 || M_HWRITE !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL stall_hold got %0d unstable cycles want 0", bad); else n_pass++;
    M_HREADY = 1'b1;
    wait_drain(1, 20, ok);
    repeat (4) @(negedge HCLK);
    n_checks++; if (ok !== 1'b1) $display("FAIL stall_drain got %b want 1", ok); else n_pass++;
    n_checks++; if (wr_ap_cnt !== 1) $display("FAIL stall_addr_phases got %0d want 1", wr_ap_cnt); else n_pass++;
    n_checks++; if (wr_log_a.size() !== 1) $display("FAIL stall_writes got %0d want 1", wr_log_a.size()); else n_pass++;
    if (wr_log_d.size() >= 1) begin
      n_checks++; if (wr_log_d[0] !== 32'hCAFE_F00D) $display("FAIL stall_data got %h want cafef00d", wr_log_d[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    M_HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_w[i] = 1'b1; op_a[i] = 32'h200 + 32'(i * 4); op_d[i] = 32'hB000_0000 + 32'(i);
    end
    run_ops(4);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge HCLK);
      #1;
      if (M_HTRANS == 2'b10) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL rmid_addr_seen got %b want 1", seen); else n_pass++;
    M_HREADY = 1'b1;
    @(negedge HCLK);
    M_HREADY = 1'b0;
    #1;
    n_checks++; if (M_HWDATA !== 32'hB000_0000) $display("FAIL rmid_wdata got %h want b0000000", M_HWDATA); else n_pass++;
    HRESETn = 1'b0;
    M_HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);
    #1;
    n_checks++; if (wbuf_empty !== 1'b1) $display("FAIL rmid_empty got %b want 1", wbuf_empty); else n_pass++;
    n_checks++; if (HREADY !== 1'b1) $display("FAIL rmid_hready got %b want 1", HREADY); else n_pass++;
    n_checks++; if (M_HTRANS !== 2'b00) $display("FAIL rmid_htrans got %b want 00", M_HTRANS); else n_pass++;
    n_checks++; if (wr_log_a.size() !== 0) $display("FAIL rmid_writes got %0d want 0", wr_log_a.size()); else n_pass++;
    n_checks++; if (wr_ap_cnt !== 1) $display("FAIL rmid_addr_phases got %0d want 1", wr_ap_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_read();
    test_refresh_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mfp_ahb_sdram_wbuf.md
Name: mfp_ahb_sdram_wbuf

Overview:
- Posted-write buffer between the MIPSfpga+ AHB-Lite system bus (slave side) and the SDRAM controller's AHB-Lite slave port (master side, `M_` prefix).
- Absorbs CPU writes with zero wait states while a FIFO slot is free, then drains them to the SDRAM controller in order.
- Reads are held until the FIFO has drained, then forwarded, so ordering is strict.
- Single outstanding downstream transfer. Single transfers only; HBURST is ignored.

Parameters:
- FIFO_LOG2, 2, log2 of the write FIFO depth (default depth 4).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low
- HADDR  in  32  upstream address
- HSEL  in  1  upstream select
- HTRANS  in  2  upstream transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are acted on
- HWRITE  in  1  upstream direction
- HSIZE  in  3  upstream size; stored and passed through
- HWDATA  in  32  upstream write data, sampled in the data phase
- HRDATA  out  32  upstream read data, registered
- HREADY  out  1  upstream ready
- HRESP  out  1  constant 0
- M_HSEL  out  1  downstream select
- M_HADDR  out  32  downstream address
- M_HTRANS  out  2  downstream transfer type: 2'b10 (NONSEQ) or 2'b00 (IDLE)
- M_HWRITE  out  1  downstream direction
- M_HSIZE  out  3  downstream size
- M_HWDATA  out  32  downstream write data
- M_HRDATA  in  32  downstream read data
- M_HREADY  in  1  downstream ready
- wbuf_empty  out  1  1 when the FIFO holds no entries

Behaviour:
Reset (HRESETn=0 at a HCLK edge):
- FIFO count=0, all pointers=0.
- HREADY=1, HRDATA=0.
- M_HTRANS=00, M_HSEL=0, M_HADDR=0, M_HWRITE=0, M_HSIZE=0, M_HWDATA=0.
- Upstream pending-phase flag cleared; master FSM returns to M_IDLE.
- Reset mid-operation discards all FIFO contents and any in-flight transfer.

Upstream address phase:
- Accepted when HSEL && HTRANS[1] && HREADY are all 1 at a clock edge.
- HADDR, HWRITE and HSIZE are registered and a data-phase flag is set.

Upstream write data phase:
- count < 2^FIFO_LOG2: HREADY=1 combinationally; at the edge push {addr, HWDATA, size}.
- FIFO full: HREADY=0 until count drops.
- A pop in the same cycle does not free a slot until the next cycle: the full check uses registered count.
- Simultaneous push and pop leaves count unchanged.
- A new address phase may be accepted in the same cycle the write data completes, giving back-to-back zero-wait writes.

Upstream read data phase:
- HREADY=0 until the downstream read completes.
- HRDATA is loaded from M_HRDATA, then HREADY=1 for exactly one cycle.
- Minimum read latency: FIFO drain time + downstream read time + 1 cycle.

Master FSM:
- M_IDLE:
  - FIFO non-empty: drive M_HSEL=1, M_HTRANS=10, M_HWRITE=1, M_HADDR/M_HSIZE=FIFO head; go to M_WADDR.
  - Else, a read data phase is pending and the FIFO is empty: drive a read address from the registered upstream address; go to M_RADDR.
  - Writes take priority over reads.
- M_WADDR: hold address signals until M_HREADY=1; then M_HTRANS=00, M_HSEL=0, M_HWDATA=head data; go to M_WDATA.
- M_WDATA:
  - Hold M_HWDATA until M_HREADY=1, then pop and go to M_IDLE.
  - When M_HREADY=1 and the FIFO holds another entry, issue the next address in the same cycle and go directly to M_WADDR.
- M_RADDR: hold until M_HREADY=1; then M_HTRANS=00; go to M_RDATA.
- M_RDATA: when M_HREADY=1, capture M_HRDATA into HRDATA, complete the upstream read, go to M_IDLE.

Downstream waits:
- M_HREADY=0 in any phase (SDRAM init, auto-refresh, access in progress) stalls the FSM with all outputs held stable.
- No timeout.

Addressing and status:
- No address decode or modification; HADDR is forwarded unchanged.
- wbuf_empty = (count==0), registered from count.

Test Plan:
- Reset with HRESETn=0 for 2 cycles -> HREADY=1, M_HTRANS=00, wbuf_empty=1, HRDATA=0.
- Single write 0x00000010 <= 0xDEADBEEF with M_HREADY tied 1 -> upstream HREADY never drops. M_HADDR=0x10, M_HWRITE=1 issued 1 cycle after the data phase; M_HWDATA=0xDEADBEEF in the following cycle; wbuf_empty returns to 1.
- Six back-to-back writes, downstream stalled with M_HREADY=0 for 20 cycles -> first 4 complete with zero wait; 5th data phase holds HREADY=0 until the first pop; all 6 appear downstream in issue order with correct data.
- Write 0x20 <= 0x12345678, then immediate read of 0x20, downstream model is RAM -> read waits for the drain; HRDATA=0x12345678 with HREADY=1 for exactly one cycle.
- Downstream M_HREADY=0 during M_WADDR for 7 cycles (refresh) -> M_HADDR, M_HTRANS and M_HWRITE are stable all 7 cycles; no duplicate write.
- HRESETn asserted while 3 entries are queued and a write is in M_WDATA -> after reset, count=0, no further downstream transfers, HREADY=1.
